dcache_tag_ctrl: RTL and testbench

// Controller for the data cache tag store SRAM. It sits between the dcache FSM and the store and

---
 rtl/dcache_tag_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_dcache_tag_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_tag_ctrl
//
// Purpose
//   Controller for the data cache tag store SRAM. Sits between the dcache FSM
//   and the store, arbitrating lookup, refill and flush traffic onto a single
//   store port. The store has no reset, so an invalidate sweep runs after reset
//   and after every flush. The store reads on the falling edge, so read data
//   for an address driven in cycle N is usable before the rising edge ending N.
//
// Store word layout: {valid, dirty, tag[TAG_WIDTH-1:0]}
//
// Ports
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   flush_i / flush_done_o         start invalidate sweep / end-of-sweep pulse
//   busy_o                         controller not idle
//   lookup_req_i, lookup_we_i,
//   lookup_index_i, lookup_tag_i   lookup request (we = store, marks line dirty)
//   lookup_gnt_o                   lookup accepted this cycle
//   lookup_valid_o, lookup_hit_o,
//   lookup_dirty_o, lookup_victim_o  registered lookup result, cycle after grant
//   refill_req_i, refill_index_i,
//   refill_tag_i, refill_dirty_i   line install request
//   refill_gnt_o                   refill written this cycle
//   ts_en_o, ts_we_o, ts_addr_o,
//   ts_wdata_o, ts_bit_en_o        tag store command
//   ts_rdata_i                     tag store read data
//   hit_count_o, miss_count_o      performance counters
//
// Configuration
//   DCACHE_TAG_CTRL_PERF_EN  when defined, hit_count_o/miss_count_o are
//                            saturating counters; otherwise tied to zero.
// -----------------------------------------------------------------------------
module dcache_tag_ctrl #(
    parameter int TAG_WIDTH = 20,
    parameter int NUM_WORDS = 256,
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int WW = TAG_WIDTH + 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic                 busy_o,
    input  logic                 lookup_req_i,
    input  logic                 lookup_we_i,
    input  logic [IW-1:0]        lookup_index_i,
    input  logic [TAG_WIDTH-1:0] lookup_tag_i,
    output logic                 lookup_gnt_o,
    output logic                 lookup_valid_o,
    output logic                 lookup_hit_o,
    output logic                 lookup_dirty_o,
    output logic [TAG_WIDTH-1:0] lookup_victim_o,
    input  logic                 refill_req_i,
    input  logic [IW-1:0]        refill_index_i,
    input  logic [TAG_WIDTH-1:0] refill_tag_i,
    input  logic                 refill_dirty_i,
    output logic                 refill_gnt_o,
    output logic                 ts_en_o,
    output logic                 ts_we_o,
    output logic [IW-1:0]        ts_addr_o,
    output logic [WW-1:0]        ts_wdata_o,
    output logic [WW-1:0]        ts_bit_en_o,
    input  logic [WW-1:0]        ts_rdata_i,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
);

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_WORDS - 1);
    localparam logic [WW-1:0] DIRTY_MASK = WW'(1) << TAG_WIDTH;

    typedef enum logic [1:0] {
        ST_SWEEP    = 2'd0,
        ST_IDLE     = 2'd1,
        ST_DIRTY_WR = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          sweep_idx_q;
    logic                   done_q;
    logic                   valid_q;
    logic                   hit_q;
    logic                   dirty_q;
    logic [TAG_WIDTH-1:0]   victim_q;
    logic [IW-1:0]          idx_q;

    logic                   flush_start;
    logic                   refill_gnt;
    logic                   lookup_gnt;
    logic                   tag_hit;

    // Read data belongs to the lookup granted this cycle.
    assign tag_hit = ts_rdata_i[WW-1] && (ts_rdata_i[TAG_WIDTH-1:0] == lookup_tag_i);

    // Store command and grants. Everything is held quiet while reset is
    // asserted so a reset landing mid-write cannot corrupt a line.
    always_comb begin
        flush_start = 1'b0;
        refill_gnt  = 1'b0;
        lookup_gnt  = 1'b0;
        ts_en_o     = 1'b0;
        ts_we_o     = 1'b0;
        ts_addr_o   = '0;
        ts_wdata_o  = '0;
        ts_bit_en_o = '0;
        if (rst_ni) begin
            case (state_q)
                ST_SWEEP: begin
                    ts_en_o     = 1'b1;
                    ts_we_o     = 1'b1;
                    ts_addr_o   = sweep_idx_q;
                    ts_bit_en_o = '1;
                end
                ST_IDLE: begin
                    if (flush_i) begin
                        flush_start = 1'b1;
                    end else if (refill_req_i) begin
                        refill_gnt  = 1'b1;
                        ts_en_o     = 1'b1;
                        ts_we_o     = 1'b1;
                        ts_addr_o   = refill_index_i;
                        ts_wdata_o  = {1'b1, refill_dirty_i, refill_tag_i};
                        ts_bit_en_o = '1;
                    end else if (lookup_req_i) begin
                        lookup_gnt  = 1'b1;
                        ts_en_o     = 1'b1;
                        ts_addr_o   = lookup_index_i;
                    end
                end
                ST_DIRTY_WR: begin
                    // Only the dirty bit is touched; valid and tag stay as read.
                    ts_en_o     = 1'b1;
                    ts_we_o     = 1'b1;
                    ts_addr_o   = idx_q;
                    ts_wdata_o  = DIRTY_MASK;
                    ts_bit_en_o = DIRTY_MASK;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_SWEEP;
            sweep_idx_q <= '0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            hit_q       <= 1'b0;
            dirty_q     <= 1'b0;
            victim_q    <= '0;
            idx_q       <= '0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                ST_SWEEP: begin
                    if (sweep_idx_q == LAST_IDX) begin
                        state_q     <= ST_IDLE;
                        sweep_idx_q <= '0;
                        done_q      <= 1'b1;
                    end else begin
                        sweep_idx_q <= sweep_idx_q + IW'(1);
                    end
                end
                ST_IDLE: begin
                    if (flush_start) begin
                        state_q     <= ST_SWEEP;
                        sweep_idx_q <= '0;
                    end else if (lookup_gnt) begin
                        valid_q  <= 1'b1;
                        hit_q    <= tag_hit;
                        dirty_q  <= ts_rdata_i[TAG_WIDTH];
                        victim_q <= ts_rdata_i[TAG_WIDTH-1:0];
                        idx_q    <= lookup_index_i;
                        if (lookup_we_i && tag_hit) begin
                            state_q <= ST_DIRTY_WR;
                        end
                    end
                end
                ST_DIRTY_WR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_SWEEP;
                    sweep_idx_q <= '0;
                end
            endcase
        end
    end

    assign flush_done_o    = done_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign lookup_gnt_o    = lookup_gnt;
    assign refill_gnt_o    = refill_gnt;
    assign lookup_valid_o  = valid_q;
    assign lookup_hit_o    = hit_q;
    assign lookup_dirty_o  = dirty_q;
    assign lookup_victim_o = victim_q;

`ifdef DCACHE_TAG_CTRL_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Counters follow the registered result; a flush start clears them even
    // if a result is being reported in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_start) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (valid_q) begin
            if (hit_q) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_tag_ctrl
//
// Directed bench for dcache_tag_ctrl with NUM_WORDS=16, TAG_WIDTH=20. Includes
// a behavioural tag store (negedge read, posedge masked write) whose contents
// start as all ones, so anything not swept would look like a valid line.
// -----------------------------------------------------------------------------
module tb_dcache_tag_ctrl;

    localparam int TW = 20;
    localparam int NW = 16;
    localparam int IW = 4;
    localparam int WW = TW + 2;

    localparam logic [WW-1:0] ALL = 22'h3F_FFFF;
    localparam logic [WW-1:0] DM  = 22'h10_0000;
    localparam logic [TW-1:0] TA  = 20'h12345;
    localparam logic [TW-1:0] TB  = 20'h00001;
    localparam logic [TW-1:0] TC  = 20'h0ABCD;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          flush_done_o;
    logic          busy_o;
    logic          lookup_req_i = 1'b0;
    logic          lookup_we_i = 1'b0;
    logic [IW-1:0] lookup_index_i = '0;
    logic [TW-1:0] lookup_tag_i = '0;
    logic          lookup_gnt_o;
    logic          lookup_valid_o;
    logic          lookup_hit_o;
    logic          lookup_dirty_o;
    logic [TW-1:0] lookup_victim_o;
    logic          refill_req_i = 1'b0;
    logic [IW-1:0] refill_index_i = '0;
    logic [TW-1:0] refill_tag_i = '0;
    logic          refill_dirty_i = 1'b0;
    logic          refill_gnt_o;
    logic          ts_en_o;
    logic          ts_we_o;
    logic [IW-1:0] ts_addr_o;
    logic [WW-1:0] ts_wdata_o;
    logic [WW-1:0] ts_bit_en_o;
    logic [WW-1:0] ts_rdata_i = '0;
    logic [31:0]   hit_count_o;
    logic [31:0]   miss_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_tag_ctrl #(.TAG_WIDTH(TW), .NUM_WORDS(NW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .flush_done_o   (flush_done_o),
        .busy_o         (busy_o),
        .lookup_req_i   (lookup_req_i),
        .lookup_we_i    (lookup_we_i),
        .lookup_index_i (lookup_index_i),
        .lookup_tag_i   (lookup_tag_i),
        .lookup_gnt_o   (lookup_gnt_o),
        .lookup_valid_o (lookup_valid_o),
        .lookup_hit_o   (lookup_hit_o),
        .lookup_dirty_o (lookup_dirty_o),
        .lookup_victim_o(lookup_victim_o),
        .refill_req_i   (refill_req_i),
        .refill_index_i (refill_index_i),
        .refill_tag_i   (refill_tag_i),
        .refill_dirty_i (refill_dirty_i),
        .refill_gnt_o   (refill_gnt_o),
        .ts_en_o        (ts_en_o),
        .ts_we_o        (ts_we_o),
        .ts_addr_o      (ts_addr_o),
        .ts_wdata_o     (ts_wdata_o),
        .ts_bit_en_o    (ts_bit_en_o),
        .ts_rdata_i     (ts_rdata_i),
        .hit_count_o    (hit_count_o),
        .miss_count_o   (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural tag store.
    logic [WW-1:0] mem [NW];
    bit            mem_init_done = 1'b0;

    always @(posedge clk_i) begin
        if (!mem_init_done) begin
            for (int i = 0; i < NW; i++) mem[i] <= ALL;
            mem_init_done <= 1'b1;
        end else if (ts_en_o && ts_we_o) begin
            mem[ts_addr_o] <= (mem[ts_addr_o] & ~ts_bit_en_o) | (ts_wdata_o & ts_bit_en_o);
        end
    end

    always @(negedge clk_i) begin
        if (ts_en_o && !ts_we_o) ts_rdata_i <= mem[ts_addr_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        flush_i      = 1'b0;
        refill_req_i = 1'b0;
        lookup_req_i = 1'b0;
        lookup_we_i  = 1'b0;
    endtask

    // Walk n sweep cycles starting at the current cycle. Requests are held
    // high (and flush pulsed) to show they are ignored; inputs drop on the
    // last cycle so nothing is granted in the first idle cycle.
    task automatic sweep_check(input int n, input bit full);
        for (int k = 0; k < n; k++) begin
            refill_req_i   = (k < n - 1);
            lookup_req_i   = (k < n - 1);
            lookup_we_i    = 1'b0;
            flush_i        = (k == 7);
            refill_index_i = 4'd3;
            refill_tag_i   = 20'h0BEEF;
            refill_dirty_i = 1'b0;
            lookup_index_i = 4'd3;
            lookup_tag_i   = TA;
            #5;
            chk("sweep_busy",   32'(busy_o), 32'd1);
            chk("sweep_we",     32'(ts_en_o & ts_we_o), 32'd1);
            chk("sweep_addr",   32'(ts_addr_o), 32'(k));
            chk("sweep_wdata",  32'(ts_wdata_o), 32'd0);
            chk("sweep_bit_en", 32'(ts_bit_en_o), 32'(ALL));
            chk("sweep_gnt",    32'({refill_gnt_o, lookup_gnt_o}), 32'd0);
            chk("sweep_done",   32'(flush_done_o), 32'd0);
            $display("sweep cycle %0d addr=%0d we=%0b", k, ts_addr_o, ts_we_o);
            tick();
        end
        flush_i = 1'b0;
        if (full) begin
            chk("sweep_end_busy", 32'(busy_o), 32'd0);
            chk("sweep_end_done", 32'(flush_done_o), 32'd1);
            tick();
            chk("done_one_cycle", 32'(flush_done_o), 32'd0);
        end
    endtask

    // Field order: inputs, registered expectations (result of previous row),
    // combinational expectations for this row.
    typedef struct {
        logic          rq;
        logic [IW-1:0] ridx;
        logic [TW-1:0] rtag;
        logic          rdirty;
        logic          lq;
        logic          lwe;
        logic [IW-1:0] lidx;
        logic [TW-1:0] ltag;
        logic          e_busy;
        logic          e_valid;
        logic          e_hit;
        logic          e_dirty;
        logic [TW-1:0] e_victim;
        logic          e_gr;
        logic          e_gl;
        logic          e_en;
        logic          e_we;
        logic [IW-1:0] e_addr;
        logic [WW-1:0] e_wdata;
        logic [WW-1:0] e_bit_en;
    } vec_t;

    vec_t vecs [15];
    int   exp_hits   = 0;
    int   exp_misses = 0;

    initial begin
        vecs[0]  = '{1'b1, 4'd3, TA, 1'b0,  1'b0, 1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 22'h21_2345, ALL};
        vecs[1]  = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd3, TA,    1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 22'h0, 22'h0};
        vecs[2]  = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b1, 1'b0, TA,    1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 22'h0, 22'h0};
        vecs[3]  = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b1, 4'd3, TA,    1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 22'h0, 22'h0};
        vecs[4]  = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd3, TA,    1'b1, 1'b1, 1'b1, 1'b0, TA,    1'b0, 1'b0, 1'b1, 1'b1, 4'd3, DM, DM};
        vecs[5]  = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd3, TA,    1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 22'h0, 22'h0};
        vecs[6]  = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd3, TB,    1'b0, 1'b1, 1'b1, 1'b1, TA,    1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 22'h0, 22'h0};
        vecs[7]  = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b1, 4'd3, TB,    1'b0, 1'b1, 1'b0, 1'b1, TA,    1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 22'h0, 22'h0};
        vecs[8]  = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b1, TA,    1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 22'h0, 22'h0};
        vecs[9]  = '{1'b1, 4'd5, TC, 1'b1,  1'b1, 1'b0, 4'd5, TC,    1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 22'h30_ABCD, ALL};
        vecs[10] = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd5, TC,    1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 22'h0, 22'h0};
        vecs[11] = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd7, 20'h0, 1'b0, 1'b1, 1'b1, 1'b1, TC,    1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 22'h0, 22'h0};
        vecs[12] = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 4'd15, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 22'h0, 22'h0};
        vecs[13] = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 22'h0, 22'h0};
        vecs[14] = '{1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 22'h0, 22'h0};

        // ---------------- reset held ----------------
        clear_inputs();
        rst_ni = 1'b0;
        repeat (3) tick();
        lookup_req_i = 1'b1;
        #5;
        chk("rst_busy",   32'(busy_o), 32'd1);
        chk("rst_ts_en",  32'(ts_en_o | ts_we_o), 32'd0);
        chk("rst_gnt",    32'({refill_gnt_o, lookup_gnt_o}), 32'd0);
        chk("rst_valid",  32'(lookup_valid_o), 32'd0);
        chk("rst_result", 32'({lookup_hit_o, lookup_dirty_o, lookup_victim_o}), 32'd0);
        chk("rst_done",   32'(flush_done_o), 32'd0);
        chk("rst_hitcnt", hit_count_o, 32'd0);
        chk("rst_misscnt", miss_count_o, 32'd0);
        $display("reset held: busy=%0b en=%0b", busy_o, ts_en_o);
        tick();

        // ---------------- reset release sweep ----------------
        rst_ni = 1'b1;
        sweep_check(NW, 1'b1);

        // ---------------- table-driven main function ----------------
        for (int i = 0; i < 15; i++) begin
            chk("tbl_busy",  32'(busy_o), 32'(vecs[i].e_busy));
            chk("tbl_valid", 32'(lookup_valid_o), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk("tbl_hit",    32'(lookup_hit_o), 32'(vecs[i].e_hit));
                chk("tbl_dirty",  32'(lookup_dirty_o), 32'(vecs[i].e_dirty));
                chk("tbl_victim", 32'(lookup_victim_o), 32'(vecs[i].e_victim));
                if (vecs[i].e_hit) exp_hits++;
                else exp_misses++;
            end
            refill_req_i   = vecs[i].rq;
            refill_index_i = vecs[i].ridx;
            refill_tag_i   = vecs[i].rtag;
            refill_dirty_i = vecs[i].rdirty;
            lookup_req_i   = vecs[i].lq;
            lookup_we_i    = vecs[i].lwe;
            lookup_index_i = vecs[i].lidx;
            lookup_tag_i   = vecs[i].ltag;
            #5;
            chk("tbl_refill_gnt", 32'(refill_gnt_o), 32'(vecs[i].e_gr));
            chk("tbl_lookup_gnt", 32'(lookup_gnt_o), 32'(vecs[i].e_gl));
            chk("tbl_ts_en", 32'(ts_en_o), 32'(vecs[i].e_en));
            chk("tbl_ts_we", 32'(ts_we_o), 32'(vecs[i].e_we));
            if (vecs[i].e_en) chk("tbl_ts_addr", 32'(ts_addr_o), 32'(vecs[i].e_addr));
            if (vecs[i].e_we) begin
                chk("tbl_ts_wdata",  32'(ts_wdata_o & ts_bit_en_o), 32'(vecs[i].e_wdata));
                chk("tbl_ts_bit_en", 32'(ts_bit_en_o), 32'(vecs[i].e_bit_en));
            end
            $display("vec %0d: gnt r/l=%0b/%0b en=%0b we=%0b addr=%0d valid=%0b hit=%0b dirty=%0b victim=%h",
                     i, refill_gnt_o, lookup_gnt_o, ts_en_o, ts_we_o, ts_addr_o,
                     lookup_valid_o, lookup_hit_o, lookup_dirty_o, lookup_victim_o);
            tick();
        end
        clear_inputs();
        tick();
`ifdef DCACHE_TAG_CTRL_PERF_EN
        chk("perf_hits",   hit_count_o, 32'(exp_hits));
        chk("perf_misses", miss_count_o, 32'(exp_misses));
`else
        chk("perf_hits_tied",   hit_count_o, 32'd0);
        chk("perf_misses_tied", miss_count_o, 32'd0);
`endif

        // ---------------- flush with pending refill ----------------
        flush_i        = 1'b1;
        refill_req_i   = 1'b1;
        refill_index_i = 4'd3;
        refill_tag_i   = TB;
        lookup_req_i   = 1'b1;
        lookup_index_i = 4'd3;
        lookup_tag_i   = TA;
        #5;
        chk("flush_no_gnt", 32'({refill_gnt_o, lookup_gnt_o}), 32'd0);
        chk("flush_no_write", 32'(ts_en_o), 32'd0);
        $display("flush issued: gnt r/l=%0b/%0b", refill_gnt_o, lookup_gnt_o);
        tick();
        sweep_check(NW, 1'b1);
        chk("flush_hitcnt_clr",  hit_count_o, 32'd0);
        chk("flush_misscnt_clr", miss_count_o, 32'd0);
        lookup_req_i   = 1'b1;
        lookup_we_i    = 1'b0;
        lookup_index_i = 4'd3;
        lookup_tag_i   = TA;
        #5;
        chk("postflush_gnt", 32'(lookup_gnt_o), 32'd1);
        tick();
        clear_inputs();
        chk("postflush_valid", 32'(lookup_valid_o), 32'd1);
        chk("postflush_hit",   32'(lookup_hit_o), 32'd0);
        chk("postflush_line",  32'({lookup_dirty_o, lookup_victim_o}), 32'd0);
        $display("post-flush lookup idx3: hit=%0b victim=%h", lookup_hit_o, lookup_victim_o);
        tick();
`ifdef DCACHE_TAG_CTRL_PERF_EN
        chk("postflush_misscnt", miss_count_o, 32'd1);
`else
        chk("postflush_misscnt", miss_count_o, 32'd0);
`endif

        // ---------------- reset during DIRTY_WR ----------------
        refill_req_i   = 1'b1;
        refill_index_i = 4'd9;
        refill_tag_i   = 20'h00ABC;
        refill_dirty_i = 1'b0;
        #5;
        chk("rdw_refill_gnt", 32'(refill_gnt_o), 32'd1);
        tick();
        clear_inputs();
        lookup_req_i   = 1'b1;
        lookup_we_i    = 1'b1;
        lookup_index_i = 4'd9;
        lookup_tag_i   = 20'h00ABC;
        #5;
        chk("rdw_store_gnt", 32'(lookup_gnt_o), 32'd1);
        tick();
        clear_inputs();
        chk("rdw_in_dirty_wr", 32'({busy_o, lookup_valid_o, lookup_hit_o}), 32'd7);
        rst_ni = 1'b0;
        #5;
        chk("rdw_write_blocked", 32'(ts_en_o | ts_we_o), 32'd0);
        $display("reset in DIRTY_WR: en=%0b we=%0b", ts_en_o, ts_we_o);
        tick();
        chk("rdw_after_rst", 32'({busy_o, lookup_valid_o, flush_done_o}), 32'd4);
        rst_ni = 1'b1;
        sweep_check(6, 1'b0);

        // ---------------- reset mid-sweep ----------------
        rst_ni = 1'b0;
        #5;
        chk("rms_en", 32'(ts_en_o), 32'd0);
        chk("rms_done", 32'(flush_done_o), 32'd0);
        tick();
        chk("rms_done2", 32'(flush_done_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        sweep_check(NW, 1'b1);
        lookup_req_i   = 1'b1;
        lookup_index_i = 4'd9;
        lookup_tag_i   = 20'h00ABC;
        tick();
        clear_inputs();
        chk("rms_lookup_valid", 32'(lookup_valid_o), 32'd1);
        chk("rms_lookup_miss",  32'({lookup_hit_o, lookup_dirty_o}), 32'd0);
        $display("post-reset lookup idx9: hit=%0b dirty=%0b", lookup_hit_o, lookup_dirty_o);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
